// File: rtl/div_seq.sv
// ---------------------------------------------------------------------------
// div_seq -- multi-cycle radix-2 restoring divider (DIV / DIVU responder).
//
// The ALU holds 'start' high with the operands and the signed flag until it
// sees 'ready'. Operands are latched on the start edge, one quotient bit is
// produced per cycle, and {remainder, quotient} is returned as a HI/LO word.
// 'annul' aborts an in-flight division so the pipeline can flush.
//
// Ports
//   clk         clock
//   rst         synchronous active-high reset
//   signed_div  1 = DIV (two's complement), 0 = DIVU; sampled with start
//   opdata1     dividend
//   opdata2     divisor
//   start       level request, held until ready is observed
//   annul       abort the current division
//   result      {remainder (HI), quotient (LO)}
//   ready       result valid; held while the result is being presented
// ---------------------------------------------------------------------------
module div_seq #(
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  signed_div,
   input  logic [DATA_W-1:0]     opdata1,
   input  logic [DATA_W-1:0]     opdata2,
   input  logic                  start,
   input  logic                  annul,
   output logic [2*DATA_W-1:0]   result,
   output logic                  ready
);

   localparam int CNT_W = $clog2(DATA_W);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ZERO = 2'd1,
      S_BUSY = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t state, state_nxt;

   // Datapath state
   logic [DATA_W-1:0] dvd;     // dividend magnitude, quotient bits shift in at the LSB
   logic [DATA_W-1:0] dsr;     // divisor magnitude
   logic [DATA_W-1:0] rem;     // partial remainder
   logic [CNT_W-1:0]  cnt;     // iteration index 0..DATA_W-1
   logic              neg_q;   // negate quotient at the end
   logic              neg_r;   // negate remainder at the end

   // Control decodes
   logic load;
   logic step;
   logic last_iter;
   logic finish;
   logic zero_done;
   logic div_zero;

   // Iteration datapath
   logic [DATA_W:0]   rem_tmp;
   logic              q_bit;
   logic [DATA_W-1:0] rem_nxt;
   logic [DATA_W-1:0] quo_raw;
   logic [DATA_W-1:0] quo_fix;
   logic [DATA_W-1:0] rem_fix;

   // Magnitude of a possibly-signed operand. The most negative value maps to
   // itself, which read as unsigned is exactly 2^(DATA_W-1).
   function automatic logic [DATA_W-1:0] mag(input logic s, input logic [DATA_W-1:0] v);
      return (s && v[DATA_W-1]) ? -v : v;
   endfunction

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // ------------------------------------------------------------------------
   // Next-state logic. annul takes priority over start everywhere.
   // ------------------------------------------------------------------------
   assign div_zero  = (opdata2 == '0);
   assign last_iter = (cnt == CNT_W'(DATA_W - 1));

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE: begin
            if (start && !annul) state_nxt = div_zero ? S_ZERO : S_BUSY;
         end
         S_ZERO: begin
            state_nxt = annul ? S_IDLE : S_DONE;
         end
         S_BUSY: begin
            if (annul || !start) state_nxt = S_IDLE;
            else if (last_iter)  state_nxt = S_DONE;
         end
         S_DONE: begin
            // No restart while start stays high: the ALU must drop it first.
            if (annul || !start) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Output / control decode
   // ------------------------------------------------------------------------
   always_comb begin
      ready     = (state == S_DONE);
      load      = (state == S_IDLE) && start && !annul;
      step      = (state == S_BUSY) && start && !annul;
      finish    = step && last_iter;
      zero_done = (state == S_ZERO) && !annul;
   end

   // ------------------------------------------------------------------------
   // One restoring step. The subtract is DATA_W+1 bits wide so that a
   // partial remainder with its MSB set (possible for unsigned divisors
   // above 2^(DATA_W-1)) never loses its top bit; in that case there is no
   // borrow and the difference fits back in DATA_W bits.
   // ------------------------------------------------------------------------
   always_comb begin
      rem_tmp = {rem, dvd[DATA_W-1]} - {1'b0, dsr};
      q_bit   = ~rem_tmp[DATA_W];
      rem_nxt = q_bit ? rem_tmp[DATA_W-1:0] : {rem[DATA_W-2:0], dvd[DATA_W-1]};
      quo_raw = {dvd[DATA_W-2:0], q_bit};
      quo_fix = neg_q ? -quo_raw : quo_raw;
      rem_fix = neg_r ? -rem_nxt : rem_nxt;
   end

   // ------------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         dvd    <= '0;
         dsr    <= '0;
         rem    <= '0;
         cnt    <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         result <= '0;
      end else begin
         if (load) begin
            // For divide-by-zero the raw dividend is kept: it becomes HI.
            dvd   <= div_zero ? opdata1 : mag(signed_div, opdata1);
            dsr   <= mag(signed_div, opdata2);
            rem   <= '0;
            cnt   <= '0;
            neg_q <= signed_div & (opdata1[DATA_W-1] ^ opdata2[DATA_W-1]);
            neg_r <= signed_div & opdata1[DATA_W-1];
         end
         if (step) begin
            dvd <= quo_raw;
            rem <= rem_nxt;
            cnt <= cnt + 1'b1;
         end
         if (finish)
            result <= {rem_fix, quo_fix};
         if (zero_done)
            result <= {dvd, {DATA_W{1'b1}}};
      end
   end

endmodule
